// File: rtl/mcp3002_reader.sv
// SPI master for the MCP3002 10-bit ADC: periodic single-ended conversions,
// each result delivered as a 10-bit word with a one-cycle valid strobe.
module mcp3002_reader #(
  parameter int CLK_FREQ          = 48_000_000,
  parameter int MCP3002_CLK_FREQ  = 800_000,
  parameter int ADC_SAMPLING_FREQ = 48_000,
  parameter bit FAST_SIMULATION   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       channel,
  output logic       adc_cs,
  output logic       adc_clk,
  output logic       adc_din,
  input  logic       adc_dout,
  output logic [9:0] sample_data,
  output logic       sample_valid,
  output logic       busy
);

  localparam int SCLK_FREQ      = FAST_SIMULATION ? 12_000_000 : MCP3002_CLK_FREQ;
  localparam int FS_FREQ        = FAST_SIMULATION ? 600_000 : ADC_SAMPLING_FREQ;
  localparam int HALF           = CLK_FREQ / (2 * SCLK_FREQ);
  localparam int SAMPLING_CYCLE = CLK_FREQ / FS_FREQ;
  localparam int TW             = (SAMPLING_CYCLE > 2) ? $clog2(SAMPLING_CYCLE) : 1;
  localparam int HW             = (HALF > 1) ? $clog2(HALF + 1) : 1;

  if ((HALF < 1) || (2 * HALF * 16 >= SAMPLING_CYCLE)) begin : g_timing_check
    $error("mcp3002_reader: a frame does not fit inside one sampling period");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t          state_r, state_n;
  logic [TW-1:0]   tcnt_r;
  logic            tick_s;
  logic [HW-1:0]   hcnt_r, hcnt_n;
  logic [3:0]      bit_r, bit_n;
  logic [9:0]      shreg_r, shreg_n;
  logic            chan_r, chan_n;
  logic            cs_r, cs_n;
  logic            sclk_r, sclk_n;
  logic            din_r, din_n;
  logic [9:0]      data_r, data_n;
  logic            valid_r, valid_n;
  logic            busy_r, busy_n;
  logic            half_end_s;

  // Command bit driven before rising edge r: start, SGL, ODD, MSBF, then zeros.
  function automatic logic cmd_bit(input logic [3:0] r, input logic odd);
    case (r)
      4'd1:    cmd_bit = 1'b1;
      4'd2:    cmd_bit = 1'b1;
      4'd3:    cmd_bit = odd;
      4'd4:    cmd_bit = 1'b1;
      default: cmd_bit = 1'b0;
    endcase
  endfunction

  // Sampling timer: free-running while enabled, parked at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_r <= '0;
    end else if (!enable) begin
      tcnt_r <= '0;
    end else if (tcnt_r == TW'(SAMPLING_CYCLE - 1)) begin
      tcnt_r <= '0;
    end else begin
      tcnt_r <= tcnt_r + TW'(1);
    end
  end

  assign tick_s     = enable && (tcnt_r == TW'(SAMPLING_CYCLE - 1));
  assign half_end_s = (hcnt_r == HW'(HALF - 1));

  // Frame sequencer: computes the next value of every register, pins included.
  always_comb begin
    state_n = state_r;
    hcnt_n  = hcnt_r;
    bit_n   = bit_r;
    shreg_n = shreg_r;
    chan_n  = chan_r;
    cs_n    = cs_r;
    sclk_n  = sclk_r;
    din_n   = din_r;
    data_n  = data_r;
    valid_n = 1'b0;
    busy_n  = busy_r;
    case (state_r)
      S_IDLE: begin
        cs_n   = 1'b1;
        sclk_n = 1'b0;
        if (tick_s) begin
          chan_n  = channel;
          cs_n    = 1'b0;
          din_n   = 1'b1;
          busy_n  = 1'b1;
          hcnt_n  = '0;
          shreg_n = '0;
          state_n = S_SETUP;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SETUP: begin
        if (half_end_s) begin
          hcnt_n  = '0;
          bit_n   = 4'd1;
          sclk_n  = 1'b1;
          state_n = S_HIGH;
        end else begin
          hcnt_n  = hcnt_r + HW'(1);
        end
      end
      S_HIGH: begin
        if (half_end_s) begin
          hcnt_n  = '0;
          shreg_n = {shreg_r[8:0], adc_dout};
          sclk_n  = 1'b0;
          din_n   = cmd_bit(bit_r + 4'd1, chan_r);
          state_n = S_LOW;
        end else begin
          hcnt_n  = hcnt_r + HW'(1);
        end
      end
      S_LOW: begin
        if (!half_end_s) begin
          hcnt_n = hcnt_r + HW'(1);
        end else if (bit_r == 4'd15) begin
          hcnt_n  = '0;
          cs_n    = 1'b1;
          din_n   = 1'b0;
          data_n  = shreg_r;
          valid_n = 1'b1;
          busy_n  = 1'b0;
          state_n = S_DONE;
        end else begin
          hcnt_n  = '0;
          bit_n   = bit_r + 4'd1;
          sclk_n  = 1'b1;
          state_n = S_HIGH;
        end
      end
      S_DONE: begin
        bit_n   = 4'd0;
        state_n = S_IDLE;
      end
      default: begin
        cs_n    = 1'b1;
        sclk_n  = 1'b0;
        din_n   = 1'b0;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops CS and SCLK at once, aborting any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      hcnt_r  <= '0;
      bit_r   <= 4'd0;
      shreg_r <= 10'd0;
      chan_r  <= 1'b0;
      cs_r    <= 1'b1;
      sclk_r  <= 1'b0;
      din_r   <= 1'b0;
      data_r  <= 10'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      hcnt_r  <= hcnt_n;
      bit_r   <= bit_n;
      shreg_r <= shreg_n;
      chan_r  <= chan_n;
      cs_r    <= cs_n;
      sclk_r  <= sclk_n;
      din_r   <= din_n;
      data_r  <= data_n;
      valid_r <= valid_n;
      busy_r  <= busy_n;
    end
  end

  assign adc_cs       = cs_r;
  assign adc_clk      = sclk_r;
  assign adc_din      = din_r;
  assign sample_data  = data_r;
  assign sample_valid = valid_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_mcp3002_reader.sv
// Bench for mcp3002_reader: an MCP3002 responder model feeds words, a
// scoreboard queue holds expected results and a monitor checks each strobe.
module tb_mcp3002_reader;

  localparam int HALF  = 48_000_000 / (2 * 12_000_000);
  localparam int SC    = 48_000_000 / 600_000;
  localparam int TCLK  = 10;
  localparam int FRAME = 2 + 31 * HALF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       channel = 1'b0;
  logic       adc_cs, adc_clk, adc_din;
  logic       adc_dout = 1'b0;
  logic [9:0] sample_data;
  logic       sample_valid, busy;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int cs_fall_cnt = 0;
  int rcount = 0;
  int din_late = 0;
  logic [3:0] cmd;
  logic [9:0] cur_word;
  logic       ch_at_start;
  time        rise_t, cs_fall_t, cs_rise_t, vt_prev, vt_last;
  bit         have_rise = 1'b0;
  logic [9:0] word_q[$];
  logic [9:0] exp_q[$];

  mcp3002_reader #(
    .CLK_FREQ(48_000_000), .MCP3002_CLK_FREQ(800_000),
    .ADC_SAMPLING_FREQ(48_000), .FAST_SIMULATION(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .channel(channel),
    .adc_cs(adc_cs), .adc_clk(adc_clk), .adc_din(adc_din), .adc_dout(adc_dout),
    .sample_data(sample_data), .sample_valid(sample_valid), .busy(busy)
  );

  always #(TCLK / 2) clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // ADC responder: frame start picks the word and records the expectation.
  always @(negedge adc_cs) begin
    if (rst_n === 1'b1) begin
      cs_fall_cnt++;
      rcount = 0; cmd = 4'd0; din_late = 0; adc_dout = 1'b0;
      cur_word = (word_q.size() > 0) ? word_q.pop_front() : 10'($urandom_range(0, 1023));
      exp_q.push_back(cur_word);
      ch_at_start = channel;
      if (have_rise) begin
        checks++;
        if ((($time - cs_rise_t) / TCLK) < SC - FRAME) begin
          errors++;
          $display("FAIL cs_gap: actual %0d required >= %0d", ($time - cs_rise_t) / TCLK, SC - FRAME);
        end
      end
      cs_fall_t = $time;
    end
  end

  always @(posedge adc_clk) begin
    if (adc_cs === 1'b0) begin
      rcount++;
      rise_t = $time;
      if (rcount <= 4) cmd = {cmd[2:0], adc_din};
      else if (adc_din !== 1'b0) din_late++;
    end
  end

  always @(negedge adc_clk) begin
    if (adc_cs === 1'b0 && rst_n === 1'b1) begin
      check("sclk_high_width", ($time - rise_t) / TCLK, HALF);
      if (rcount == 4) adc_dout = 1'b0;
      else if (rcount >= 5 && rcount <= 14) adc_dout = cur_word[14 - rcount];
    end
  end

  always @(posedge adc_cs) begin
    if (rst_n === 1'b1 && adc_cs === 1'b1) begin
      check("sclk_pulse_count", rcount, 15);
      check("din_cmd", cmd, {1'b1, 1'b1, ch_at_start, 1'b1});
      check("din_tail_zero", din_late, 0);
      check("cs_low_len", ($time - cs_fall_t) / TCLK, 31 * HALF);
      cs_rise_t = $time;
      have_rise = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy_vs_cs", busy, !adc_cs);
      if (sample_valid === 1'b1) begin
        valid_cnt++;
        vt_prev = vt_last;
        vt_last = $time;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected: actual %h required no strobe", sample_data);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if (sample_data !== e) begin
            errors++;
            $display("FAIL sample_data: actual %h required %h", sample_data, e);
          end
        end
      end
    end
  end

  task automatic wait_valids(input int n, input int budget, input bit rand_ch, input string name);
    int target;
    int k;
    target = valid_cnt + n;
    k = 0;
    while (valid_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
      if (rand_ch && $urandom_range(0, 15) == 0) channel = 1'($urandom_range(0, 1));
    end
    check({name, "_timeout"}, (valid_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_r(input int r, input string name);
    int k;
    k = 0;
    while (!(adc_cs === 1'b0 && rcount == r) && k < 2 * SC) begin
      @(negedge clk);
      k++;
    end
    check({name, "_timeout"}, (k < 2 * SC) ? 1 : 0, 1);
  endtask

  initial begin
    int n;
    int falls0;
    // 1: reset state, then idle with enable low
    repeat (3) @(negedge clk);
    check("rst_cs", adc_cs, 1);
    check("rst_sclk", adc_clk, 0);
    check("rst_din", adc_din, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5 * SC) @(negedge clk);
    check("idle_no_cs", cs_fall_cnt, 0);

    // 2: single frame, channel 0
    channel = 1'b0;
    word_q.push_back(10'h2A5);
    enable = 1'b1;
    n = 0;
    while (adc_cs !== 1'b0 && n < 2 * SC) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    wait_valids(1, 2 * SC, 1'b0, "single");
    n = valid_cnt;
    repeat (2 * SC) @(negedge clk);
    check("single_one_strobe", valid_cnt - n, 0);
    check("single_data_hold", sample_data, 10'h2A5);

    // 3: channel 1, extreme codes, strobe spacing
    channel = 1'b1;
    word_q.push_back(10'h3FF);
    word_q.push_back(10'h000);
    enable = 1'b1;
    wait_valids(2, 3 * SC, 1'b0, "extremes");
    check("valid_spacing", (vt_last - vt_prev) / TCLK, SC);

    // 4: sine table with random channel changes
    for (int i = 0; i < 256; i++) begin
      int v;
      v = $rtoi(511.5 + 511.0 * $sin(6.283185307 * i / 256.0));
      word_q.push_back(10'(v));
    end
    wait_valids(258, 260 * SC, 1'b1, "sine");
    check("sine_words_consumed", word_q.size(), 0);

    // 5: enable dropped mid-frame, then re-enabled
    wait_r(8, "drop_r8");
    enable = 1'b0;
    wait_valids(1, 2 * SC, 1'b0, "drop_finish");
    falls0 = cs_fall_cnt;
    repeat (3 * SC) @(negedge clk);
    check("drop_no_new_frame", cs_fall_cnt - falls0, 0);
    enable = 1'b1;
    n = 0;
    while (n < 2 * SC) begin
      @(posedge clk);
      #1;
      n++;
      if (adc_cs === 1'b0) break;
    end
    check("reenable_latency", n, SC);

    // 6: reset mid-frame
    wait_r(10, "rst_r10");
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_cs", adc_cs, 1);
    check("abort_sclk", adc_clk, 0);
    check("abort_busy", busy, 0);
    check("abort_data", sample_data, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valids(2, 3 * SC, 1'b1, "after_reset");

    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 2 * SC) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
